// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a programmed number of unsigned products arriving from the registered
// multiplier stage (one MAC / dot-product reduction) and presents the final
// sum with a sticky overflow flag over a valid/ready handshake.
//
// Parameters:
//   PROD_W  width of each incoming product
//   ACC_W   accumulator / result width (must be >= PROD_W)
//   LEN_W   width of the product-count field
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   start      begin a reduction (sampled only in IDLE)
//   len        number of products to sum, latched on start
//   in_valid   in_prod holds a valid product
//   in_ready   block accepts a product this cycle (high in ACCUM)
//   in_prod    unsigned product
//   out_valid  out_sum / out_ovf valid (high in DONE)
//   out_ready  downstream accepts the result
//   out_sum    final sum
//   out_ovf    sticky: a carry out of ACC_W occurred during this reduction
//   busy       high in ACCUM and DONE
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   - on overflow the accumulator clamps to all-ones for the rest
//               of the reduction
//   undefined - the accumulator wraps modulo 2^ACC_W
//   out_ovf records the overflow in both builds; ports and timing identical.
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [LEN_W-1:0]   cnt;

    logic               accept;
    logic [ACC_W:0]     sum_wide;
    logic               ovf_nxt;
    logic [ACC_W-1:0]   acc_nxt;
    logic               last;

    // Full-width add keeping the carry out of bit ACC_W-1 in the top bit.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0]  a,
                                                 input logic [PROD_W-1:0] p);
        return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    endfunction

`ifdef ACC_SATURATE_EN
    // Once any overflow has happened in this reduction the accumulator is
    // pinned at full scale.
    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] s,
                                                  input logic             sticky);
        return sticky ? {ACC_W{1'b1}} : s;
    endfunction
`endif

    assign accept = in_valid & in_ready;
    assign last   = (cnt == LEN_W'(1));

    always_comb begin
        sum_wide = add_carry(acc, in_prod);
        ovf_nxt  = ovf | sum_wide[ACC_W];
`ifdef ACC_SATURATE_EN
        acc_nxt  = saturate(sum_wide[ACC_W-1:0], ovf_nxt);
`else
        acc_nxt  = sum_wide[ACC_W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs, all decoded from the current state
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator, count and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            acc <= '0;
                            ovf <= 1'b0;
                            cnt <= len;
                        end else begin
                            // Empty reduction: result is zero, no products taken
                            out_sum <= '0;
                            out_ovf <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        ovf <= ovf_nxt;
                        cnt <= cnt - LEN_W'(1);
                        if (last) begin
                            out_sum <= acc_nxt;
                            out_ovf <= ovf_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Drives two instances with identical stimulus: one with the default 32-bit
// accumulator and one with a 16-bit accumulator so that overflow behaviour
// is reachable with short reductions. Expected results come from the plain
// arithmetic total of the accepted products.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [31:0] out_sum_a;
    logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [15:0] out_sum_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(16), .ACC_W(32), .LEN_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_ovf(out_ovf_a), .busy(busy_a)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result of a reduction as a function of the true total.
    function automatic longint ref_sum(input longint total, input int w);
        longint lim = longint'(1) << w;
`ifdef ACC_SATURATE_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    function automatic logic ref_ovf(input longint total, input int w);
        return total >= (longint'(1) << w);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full reduction. items: product values, negative entries are bubbles.
    // hold: number of DONE cycles with out_ready low before the handshake.
    task automatic run_red(input string name, input int n, input int items[$], input int hold);
        longint      total = 0;
        logic [31:0] held_a;
        logic [15:0] held_b;
        start    = 1'b1;
        len      = 8'(n);
        in_valid = 1'b0;
        step();
        start = 1'b0;
        len   = 8'($urandom);   // later len changes must not matter
        chk({name, "_busy"}, {62'd0, busy_a, busy_b}, 64'd3);
        foreach (items[i]) begin
            chk({name, "_in_ready"}, {62'd0, in_ready_a, in_ready_b}, 64'd3);
            chk({name, "_early_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd0);
            if (items[i] < 0) begin
                in_valid = 1'b0;
                in_prod  = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_prod  = 16'(items[i]);
                total   += longint'(items[i]);
            end
            step();
        end
        in_valid = 1'b0;
        chk({name, "_out_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd3);
        chk({name, "_in_ready_done"}, {62'd0, in_ready_a, in_ready_b}, 64'd0);
        chk({name, "_sum32"}, 64'(out_sum_a), 64'(ref_sum(total, 32)));
        chk({name, "_ovf32"}, 64'(out_ovf_a), 64'(ref_ovf(total, 32)));
        chk({name, "_sum16"}, 64'(out_sum_b), 64'(ref_sum(total, 16)));
        chk({name, "_ovf16"}, 64'(out_ovf_b), 64'(ref_ovf(total, 16)));
        held_a = out_sum_a;
        held_b = out_sum_b;
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            in_prod   = 16'($urandom);
            step();
            chk({name, "_hold_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd3);
            chk({name, "_hold_ready"}, {62'd0, in_ready_a, in_ready_b}, 64'd0);
            chk({name, "_hold_sum"}, {out_sum_a, 16'd0, out_sum_b}, {held_a, 16'd0, held_b});
        end
        // Handshake with start asserted in the same cycle: start is ignored
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        in_valid  = 1'b0;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        chk({name, "_idle_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd0);
        chk({name, "_idle_busy"}, {62'd0, busy_a, busy_b}, 64'd0);
        step();
        chk({name, "_no_restart"}, {62'd0, busy_a, busy_b}, 64'd0);
    endtask

    initial begin
        int q[$];
        int n;
        reset_n   = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_prod   = 16'd0;
        out_ready = 1'b0;
        #12;
        chk("reset_outputs",
            {out_sum_a, out_sum_b, 12'd0, in_ready_a, out_valid_a, out_ovf_a, busy_a},
            64'd0);
        chk("reset_outputs_b", {60'd0, in_ready_b, out_valid_b, out_ovf_b, busy_b}, 64'd0);
        reset_n = 1'b1;
        step();

        // Basic sum, back-to-back
        q = '{1, 2, 3, 4};
        run_red("basic", 4, q, 0);

        // Bubbles between accepts
        q = '{'hFFFF, -1, -1, 'h0001, -1, 'h0010};
        run_red("bubbles", 3, q, 1);

        // Back-pressure in DONE
        q = '{'h1234, 'h4321};
        run_red("backpressure", 2, q, 5);

        // Empty reduction
        q = '{};
        run_red("len0", 0, q, 2);

        // Overflow on the 16-bit instance
        q = '{'hFFFF, 'h0002};
        run_red("overflow", 2, q, 0);

        // Maximum length, all full-scale products
        q = '{};
        for (int i = 0; i < 255; i++) q.push_back('hFFFF);
        run_red("maxlen", 255, q, 0);

        // Randomized reductions with bubbles and back-pressure
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 12);
            q = '{};
            while (n > 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    q.push_back(-1);
                end else begin
                    q.push_back((r % 2 == 0) ? int'($urandom_range(0, 'hFFFF))
                                             : int'($urandom_range('hF000, 'hFFFF)));
                    n--;
                end
            end
            n = 0;
            foreach (q[i]) if (q[i] >= 0) n++;
            run_red("random", n, q, $urandom_range(0, 3));
        end

        // Reset in the middle of a reduction
        start = 1'b1;
        len   = 8'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_prod  = 16'd100;
        step();
        in_prod  = 16'd200;
        step();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("midreset_a",
            {out_sum_a, 28'd0, in_ready_a, out_valid_a, out_ovf_a, busy_a}, 64'd0);
        chk("midreset_b",
            {32'd0, out_sum_b, 12'd0, in_ready_b, out_valid_b, out_ovf_b, busy_b}, 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("after_reset_idle", {62'd0, busy_a, busy_b}, 64'd0);
        q = '{7};
        run_red("post_reset", 1, q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
